// File: rtl/ddr_ring_pkg.sv
// ddr_ring_pkg: shared state codes, widths and burst address helper for the DDR ring scheduler
package ddr_ring_pkg;
   localparam int BURST_LEN_W = 10;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WR   = 2'd1;
   localparam logic [1:0] RD   = 2'd2;
   function automatic logic [63:0] burst_addr(input logic [63:0] base, input logic [63:0] ptr,
                                              input logic [63:0] len);
      return base + ptr * len;
   endfunction
endpackage

// File: rtl/ddr_ring_ptr.sv
// ddr_ring_ptr: ring burst pointer that advances on inc_i and wraps from DEPTH-1 to 0
// Ports: clk, rst (sync, active-high), inc_i (advance one burst), ptr_o (current burst index)
module ddr_ring_ptr #(
   parameter int DEPTH = 1024,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc_i,
   output logic [PW-1:0] ptr_o
);
   logic [PW-1:0] ptr_q, ptr_d;
   assign ptr_d = !inc_i ? ptr_q : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
   assign ptr_o = ptr_q;
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
endmodule

// File: rtl/ddr_ring_sched.sv
// ddr_ring_sched: schedules DDR2 burst writes/reads as a circular buffer between the AD and wavelet FIFOs
// Ports: phy_clk/rst (sync, active-high); local_init_done gates scheduling; w_req/r_req FIFO flags;
//   wr_burst_* / rd_burst_* burst-engine handshake (req/len/addr out, data_req/data_valid/finish in);
//   level/full/empty report ring occupancy in bursts.
// Option: define DDR_RING_STARVE_GUARD_EN to force a pending read after MAX_WR_STREAK consecutive writes.
module ddr_ring_sched
   import ddr_ring_pkg::*;
#(
   parameter int ADDR_WIDTH    = 25,
   parameter int BURST_LEN     = 4,
   parameter int BASE_ADDR     = 0,
   parameter int DEPTH_BURSTS  = 1024,
   parameter int MAX_WR_STREAK = 8
) (
   input  logic                               phy_clk,
   input  logic                               rst,
   input  logic                               local_init_done,
   input  logic                               w_req,
   input  logic                               r_req,
   output logic                               wr_burst_req,
   output logic [BURST_LEN_W-1:0]             wr_burst_len,
   output logic [ADDR_WIDTH-1:0]              wr_burst_addr,
   input  logic                               wr_burst_data_req,
   input  logic                               wr_burst_finish,
   output logic                               rd_burst_req,
   output logic [BURST_LEN_W-1:0]             rd_burst_len,
   output logic [ADDR_WIDTH-1:0]              rd_burst_addr,
   input  logic                               rd_burst_data_valid,
   input  logic                               rd_burst_finish,
   output logic [$clog2(DEPTH_BURSTS+1)-1:0]  level,
   output logic                               full,
   output logic                               empty
);
   localparam int PW = $clog2(DEPTH_BURSTS);
   localparam int LW = $clog2(DEPTH_BURSTS + 1);
   logic [1:0]            state_q, state_d;
   logic                  wr_req_q, wr_req_d, rd_req_q, rd_req_d;
   logic [LW-1:0]         level_q, level_d;
   logic                  full_q, empty_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic                  wr_elig, rd_elig, force_rd, go_wr, go_rd, wr_done, rd_done;
   assign wr_elig = w_req & ~full_q;
   assign rd_elig = r_req & ~empty_q;
   assign go_wr   = local_init_done & (state_q == IDLE) & wr_elig & ~force_rd;
   assign go_rd   = local_init_done & (state_q == IDLE) & rd_elig & ~go_wr;
   // Finish pulses only count in the matching burst state; strays are dropped.
   assign wr_done = (state_q == WR) & wr_burst_finish;
   assign rd_done = (state_q == RD) & rd_burst_finish;
`ifdef DDR_RING_STARVE_GUARD_EN
   localparam int SW = $clog2(MAX_WR_STREAK + 1);
   logic [SW-1:0] streak_q, streak_d;
   assign force_rd = (streak_q == SW'(MAX_WR_STREAK)) & rd_elig;
   // Saturates so a read that becomes eligible late is still forced.
   assign streak_d = go_rd ? '0 : (go_wr & (streak_q != SW'(MAX_WR_STREAK))) ? streak_q + SW'(1) : streak_q;
   always_ff @(posedge phy_clk) begin
      if (rst) streak_q <= '0;
      else     streak_q <= streak_d;
   end
`else
   assign force_rd = 1'b0;
`endif
   always_comb begin
      state_d   = !local_init_done ? IDLE : go_wr ? WR : go_rd ? RD : (wr_done | rd_done) ? IDLE : state_q;
      wr_req_d  = local_init_done & (go_wr | (wr_req_q & ~wr_burst_data_req & ~wr_burst_finish));
      rd_req_d  = local_init_done & (go_rd | (rd_req_q & ~rd_burst_data_valid & ~rd_burst_finish));
      level_d   = level_q + LW'(wr_done) - LW'(rd_done);
      // Addresses trail the pointers by a cycle; the mandatory IDLE cycle hides that lag.
      wr_addr_d = ADDR_WIDTH'(burst_addr(64'(BASE_ADDR), 64'(wr_ptr), 64'(BURST_LEN)));
      rd_addr_d = ADDR_WIDTH'(burst_addr(64'(BASE_ADDR), 64'(rd_ptr), 64'(BURST_LEN)));
   end
   always_ff @(posedge phy_clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wr_req_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         level_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         wr_addr_q <= ADDR_WIDTH'(BASE_ADDR);
         rd_addr_q <= ADDR_WIDTH'(BASE_ADDR);
      end else begin
         state_q   <= state_d;
         wr_req_q  <= wr_req_d;
         rd_req_q  <= rd_req_d;
         level_q   <= level_d;
         full_q    <= level_d == LW'(DEPTH_BURSTS);
         empty_q   <= level_d == '0;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
      end
   end
   ddr_ring_ptr #(.DEPTH(DEPTH_BURSTS), .PW(PW)) u_wr_ptr (
      .clk(phy_clk), .rst(rst), .inc_i(wr_done), .ptr_o(wr_ptr)
   );
   ddr_ring_ptr #(.DEPTH(DEPTH_BURSTS), .PW(PW)) u_rd_ptr (
      .clk(phy_clk), .rst(rst), .inc_i(rd_done), .ptr_o(rd_ptr)
   );
   assign wr_burst_req  = wr_req_q;
   assign rd_burst_req  = rd_req_q;
   assign wr_burst_len  = BURST_LEN_W'(BURST_LEN);
   assign rd_burst_len  = BURST_LEN_W'(BURST_LEN);
   assign wr_burst_addr = wr_addr_q;
   assign rd_burst_addr = rd_addr_q;
   assign level         = level_q;
   assign full          = full_q;
   assign empty         = empty_q;
endmodule

// File: tb/tb_ddr_ring_sched.sv
// tb_ddr_ring_sched: scoreboard bench for ddr_ring_sched with an emulated burst engine and a ring-occupancy model
module tb_ddr_ring_sched;
   localparam int AW = 25, BL = 4, BASE = 0, DEPTH = 4, MAXS = 2;
   localparam int LW = $clog2(DEPTH + 1);
   logic phy_clk = 0, rst = 1, local_init_done = 0, w_req = 0, r_req = 0;
   logic wr_burst_data_req = 0, wr_burst_finish = 0, rd_burst_data_valid = 0, rd_burst_finish = 0;
   logic wr_burst_req, rd_burst_req, full, empty;
   logic [9:0] wr_burst_len, rd_burst_len;
   logic [AW-1:0] wr_burst_addr, rd_burst_addr;
   logic [LW-1:0] level;
   ddr_ring_sched #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .BASE_ADDR(BASE), .DEPTH_BURSTS(DEPTH),
                    .MAX_WR_STREAK(MAXS)) dut (
      .phy_clk(phy_clk), .rst(rst), .local_init_done(local_init_done), .w_req(w_req), .r_req(r_req),
      .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
      .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
      .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
      .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
      .level(level), .full(full), .empty(empty)
   );
   always #5 phy_clk = ~phy_clk;
   typedef struct {int kind; int addr;} exp_t;
   exp_t exp_q[$];
   int errors = 0, checks = 0, seen = 0, done = 0;
   bit eng_en = 0;
   int m_level = 0, m_wr = 0, m_rd = 0, m_streak = 0;
   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask
   task automatic cyc();
      @(posedge phy_clk);
      #1;
   endtask
   task automatic pop(input int kind, input int addr);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected grant: got kind %0d addr %0d, expected none", kind, addr);
      end else begin
         e = exp_q.pop_front();
         chk("grant kind", kind, e.kind);
         chk("grant addr", addr, e.addr);
      end
      seen++;
   endtask
   initial begin : monitor
      bit pw, pr;
      pw = 0;
      pr = 0;
      forever begin
         cyc();
         if (wr_burst_req && !pw) pop(1, int'(wr_burst_addr));
         if (rd_burst_req && !pr) pop(2, int'(rd_burst_addr));
         pw = wr_burst_req;
         pr = rd_burst_req;
      end
   end
   initial begin : engine
      bit w;
      int a, d;
      forever begin
         cyc();
         if (eng_en && (wr_burst_req || rd_burst_req)) begin
            w = wr_burst_req;
            a = w ? int'(wr_burst_addr) : int'(rd_burst_addr);
            d = $urandom_range(0, 2);
            repeat (d) begin
               cyc();
               chk("req held", w ? wr_burst_req : rd_burst_req, 1);
            end
            for (int i = 0; i < BL; i++) begin
               if (w) wr_burst_data_req = 1; else rd_burst_data_valid = 1;
               cyc();
               wr_burst_data_req = 0;
               rd_burst_data_valid = 0;
               if (i == 0) chk("req cleared on first beat", w ? wr_burst_req : rd_burst_req, 0);
            end
            chk("addr held", w ? int'(wr_burst_addr) : int'(rd_burst_addr), a);
            if (w) wr_burst_finish = 1; else rd_burst_finish = 1;
            cyc();
            wr_burst_finish = 0;
            rd_burst_finish = 0;
            done++;
         end
      end
   end
   task automatic model_reset();
      m_level = 0;
      m_wr = 0;
      m_rd = 0;
      m_streak = 0;
      exp_q.delete();
   endtask
   task automatic check_idle_reset(input string tag);
      chk({tag, " level"}, int'(level), 0);
      chk({tag, " empty"}, int'(empty), 1);
      chk({tag, " full"}, int'(full), 0);
      chk({tag, " wr req"}, int'(wr_burst_req), 0);
      chk({tag, " rd req"}, int'(rd_burst_req), 0);
      chk({tag, " wr addr"}, int'(wr_burst_addr), BASE);
      chk({tag, " rd addr"}, int'(rd_burst_addr), BASE);
   endtask
   task automatic issue(input bit w, input bit r, output int g);
      bit wr_el, rd_el, frc, any;
      int s0, lim;
      wr_el = w && m_level < DEPTH;
      rd_el = r && m_level > 0;
      frc = 0;
`ifdef DDR_RING_STARVE_GUARD_EN
      frc = rd_el && m_streak >= MAXS;
`endif
      g = (wr_el && !frc) ? 1 : rd_el ? 2 : 0;
      w_req = w;
      r_req = r;
      if (g == 0) begin
         any = 0;
         repeat (4) begin
            cyc();
            any |= wr_burst_req | rd_burst_req;
         end
         chk("no grant when ineligible", int'(any), 0);
         w_req = 0;
         r_req = 0;
         return;
      end
      exp_q.push_back('{g, BASE + ((g == 1 ? m_wr : m_rd) % DEPTH) * BL});
      s0 = seen;
      lim = 0;
      while (seen == s0 && lim < 20) begin
         cyc();
         lim++;
      end
      w_req = 0;
      r_req = 0;
      if (seen == s0) begin
         chk("grant timeout", 0, 1);
         exp_q.delete();
         g = 0;
         return;
      end
      m_streak = (g == 2) ? 0 : (m_streak < MAXS ? m_streak + 1 : MAXS);
   endtask
   task automatic txn(input bit w, input bit r);
      int g, d0, lim;
      d0 = done;
      issue(w, r, g);
      if (g == 0) return;
      lim = 0;
      while (done == d0 && lim < 40) begin
         cyc();
         lim++;
      end
      if (done == d0) begin
         chk("burst finish timeout", 0, 1);
         return;
      end
      if (g == 1) begin m_wr++; m_level++; end
      else begin m_rd++; m_level--; end
      cyc();
      chk("level", int'(level), m_level);
      chk("full", int'(full), int'(m_level == DEPTH));
      chk("empty", int'(empty), int'(m_level == 0));
   endtask
   task automatic do_reset();
      rst = 1;
      cyc();
      cyc();
      rst = 0;
      model_reset();
   endtask
   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end
   initial begin : main
      int g;
      cyc();
      do_reset();
      local_init_done = 1;
      check_idle_reset("reset");
      chk("wr len", int'(wr_burst_len), BL);
      chk("rd len", int'(rd_burst_len), BL);
      eng_en = 1;
      txn(1, 0);
      txn(1, 0);
      txn(1, 0);
      repeat (3) txn(0, 1);
      txn(0, 1);
      do_reset();
      repeat (4) txn(1, 0);
      txn(1, 0);
      txn(0, 1);
      txn(1, 0);
      repeat (3) txn(0, 1);
      repeat (3) txn(1, 1);
      txn(0, 1);
      eng_en = 0;
      issue(1, 0, g);
      local_init_done = 0;
      cyc();
      chk("init drop wr req", int'(wr_burst_req), 0);
      chk("init drop level", int'(level), m_level);
      cyc();
      local_init_done = 1;
      eng_en = 1;
      txn(1, 0);
      eng_en = 0;
      issue(0, 1, g);
      rst = 1;
      cyc();
      rst = 0;
      model_reset();
      check_idle_reset("mid-read reset");
      rd_burst_finish = 1;
      cyc();
      rd_burst_finish = 0;
      wr_burst_finish = 1;
      cyc();
      wr_burst_finish = 0;
      cyc();
      chk("stray finish level", int'(level), 0);
      chk("stray finish empty", int'(empty), 1);
      eng_en = 1;
      txn(1, 0);
      chk("wr addr after reset", int'(wr_burst_addr), BASE + BL);
      repeat (150) txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat (4) cyc();
      chk("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
